tl_mig_bridge: RTL and testbench

TL_MIG_BRIDGE -- requirements
Module: tl_mig_bridge

---
 rtl/tl_mig_bridge.sv | 171 +++++++++++++++++
 tb/tb_tl_mig_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tl_mig_bridge.sv
// tl_mig_bridge: single-outstanding TL-UL slave to Xilinx MIG user-interface bridge
//   clock/reset : interconnect_clock_i, interconnect_reset_ni (async, active-low)
//   slave_a_*   : TL-UL A channel (Get / PutFull / PutPartial, one beat of 128 bits)
//   slave_d_*   : TL-UL D channel, registered, held until slave_d_ready
//   app_*       : MIG command, write-data and read-return channels
module tl_mig_bridge #(
    parameter int TL_RS = 5
) (
    input  logic              interconnect_clock_i,
    input  logic              interconnect_reset_ni,
    input  logic [2:0]        slave_a_opcode,
    input  logic [3:0]        slave_a_size,
    input  logic [TL_RS-1:0]  slave_a_source,
    input  logic [27:0]       slave_a_address,
    input  logic [15:0]       slave_a_mask,
    input  logic [127:0]      slave_a_data,
    input  logic              slave_a_valid,
    output logic              slave_a_ready,
    output logic [2:0]        slave_d_opcode,
    output logic [3:0]        slave_d_size,
    output logic [TL_RS-1:0]  slave_d_source,
    output logic              slave_d_denied,
    output logic [127:0]      slave_d_data,
    output logic              slave_d_corrupt,
    output logic              slave_d_valid,
    input  logic              slave_d_ready,
    output logic [27:0]       app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [127:0]      app_wdf_data,
    output logic [15:0]       app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic [127:0]      app_rd_data,
    input  logic              app_rd_data_valid,
    input  logic              app_rd_data_end
);
    typedef enum logic [2:0] {IDLE, WRITE, RD_CMD, RD_WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic               cmd_done_q, cmd_done_d, wdf_done_q, wdf_done_d;
    logic               a_ready_q, a_ready_d;
    logic               app_en_q, app_en_d, wdf_wren_q, wdf_wren_d;
    logic [2:0]         app_cmd_q, app_cmd_d;
    logic [27:0]        app_addr_q, app_addr_d;
    logic [127:0]       wdf_data_q, wdf_data_d;
    logic [15:0]        wdf_mask_q, wdf_mask_d;
    logic [2:0]         d_opcode_q, d_opcode_d;
    logic [3:0]         d_size_q, d_size_d;
    logic [TL_RS-1:0]   d_source_q, d_source_d;
    logic               d_denied_q, d_denied_d, d_corrupt_q, d_corrupt_d, d_valid_q, d_valid_d;
    logic [127:0]       d_data_q, d_data_d;
    logic               supported, data_op, cmd_hs, wdf_hs;
    logic               unused_in;

    // single-beat MIG configuration: read end marker and sub-beat address bits carry no information
    assign unused_in = ^{app_rd_data_end, slave_a_address[3:0]};

    always_comb begin
        state_d     = state_q;
        cmd_done_d  = cmd_done_q;
        wdf_done_d  = wdf_done_q;
        app_cmd_d   = app_cmd_q;
        app_addr_d  = app_addr_q;
        wdf_data_d  = wdf_data_q;
        wdf_mask_d  = wdf_mask_q;
        d_opcode_d  = d_opcode_q;
        d_size_d    = d_size_q;
        d_source_d  = d_source_q;
        d_denied_d  = d_denied_q;
        d_corrupt_d = d_corrupt_q;
        d_data_d    = d_data_q;
        cmd_hs      = app_en_q & app_rdy;
        wdf_hs      = wdf_wren_q & app_wdf_rdy;
        supported   = (slave_a_opcode == 3'd0 || slave_a_opcode == 3'd1 || slave_a_opcode == 3'd4)
                      && slave_a_size <= 4'd4;
        // opcodes 2..4 expect AccessAckData; a refused one returns corrupt data
        data_op     = slave_a_opcode inside {3'd2, 3'd3, 3'd4};
        case (state_q)
            IDLE: if (slave_a_valid && a_ready_q) begin
                cmd_done_d  = 1'b0;
                wdf_done_d  = 1'b0;
                app_cmd_d   = slave_a_opcode == 3'd4 ? 3'b001 : 3'b000;
                app_addr_d  = {slave_a_address[27:4], 4'b0};
                wdf_data_d  = slave_a_data;
                wdf_mask_d  = ~slave_a_mask;
                d_opcode_d  = {2'b0, data_op};
                d_size_d    = slave_a_size;
                d_source_d  = slave_a_source;
                d_denied_d  = ~supported;
                d_corrupt_d = ~supported & data_op;
                d_data_d    = '0;
                state_d     = !supported ? RESP : slave_a_opcode == 3'd4 ? RD_CMD : WRITE;
            end
            WRITE: begin
                cmd_done_d = cmd_done_q | cmd_hs;
                wdf_done_d = wdf_done_q | wdf_hs;
                state_d    = cmd_done_d && wdf_done_d ? RESP : WRITE;
            end
            RD_CMD:  state_d = cmd_hs ? RD_WAIT : RD_CMD;
            RD_WAIT: if (app_rd_data_valid) begin
                d_data_d = app_rd_data;
                state_d  = RESP;
            end
            RESP:    state_d = slave_d_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        a_ready_d  = state_d == IDLE;
        app_en_d   = (state_d == WRITE && !cmd_done_d) || state_d == RD_CMD;
        wdf_wren_d = state_d == WRITE && !wdf_done_d;
        d_valid_d  = state_d == RESP;
    end

    always_ff @(posedge interconnect_clock_i or negedge interconnect_reset_ni) begin
        if (!interconnect_reset_ni) begin
            state_q     <= IDLE;
            cmd_done_q  <= 1'b0;
            wdf_done_q  <= 1'b0;
            a_ready_q   <= 1'b0;
            app_en_q    <= 1'b0;
            wdf_wren_q  <= 1'b0;
            app_cmd_q   <= '0;
            app_addr_q  <= '0;
            wdf_data_q  <= '0;
            wdf_mask_q  <= '0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            d_data_q    <= '0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_done_q  <= cmd_done_d;
            wdf_done_q  <= wdf_done_d;
            a_ready_q   <= a_ready_d;
            app_en_q    <= app_en_d;
            wdf_wren_q  <= wdf_wren_d;
            app_cmd_q   <= app_cmd_d;
            app_addr_q  <= app_addr_d;
            wdf_data_q  <= wdf_data_d;
            wdf_mask_q  <= wdf_mask_d;
            d_opcode_q  <= d_opcode_d;
            d_size_q    <= d_size_d;
            d_source_q  <= d_source_d;
            d_denied_q  <= d_denied_d;
            d_corrupt_q <= d_corrupt_d;
            d_data_q    <= d_data_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign slave_a_ready   = a_ready_q;
    assign slave_d_opcode  = d_opcode_q;
    assign slave_d_size    = d_size_q;
    assign slave_d_source  = d_source_q;
    assign slave_d_denied  = d_denied_q;
    assign slave_d_data    = d_data_q;
    assign slave_d_corrupt = d_corrupt_q;
    assign slave_d_valid   = d_valid_q;
    assign app_addr        = app_addr_q;
    assign app_cmd         = app_cmd_q;
    assign app_en          = app_en_q;
    assign app_wdf_data    = wdf_data_q;
    assign app_wdf_mask    = wdf_mask_q;
    assign app_wdf_wren    = wdf_wren_q;
    assign app_wdf_end     = wdf_wren_q;
endmodule

// File: tb/tb_tl_mig_bridge.sv
// tb_tl_mig_bridge: directed self-checking bench for tl_mig_bridge
module tb_tl_mig_bridge;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   a_opcode = '0;
    logic [3:0]   a_size = '0;
    logic [4:0]   a_source = '0;
    logic [27:0]  a_address = '0;
    logic [15:0]  a_mask = '0;
    logic [127:0] a_data = '0;
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [2:0]   d_opcode;
    logic [3:0]   d_size;
    logic [4:0]   d_source;
    logic         d_denied, d_corrupt, d_valid;
    logic [127:0] d_data;
    logic         d_ready = 1'b0;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren, app_wdf_end;
    logic         app_rdy = 1'b1;
    logic         app_wdf_rdy = 1'b1;
    logic [127:0] app_rd_data = '0;
    logic         app_rd_data_valid = 1'b0;
    logic         app_rd_data_end = 1'b0;
    int           n_cmp = 0;
    int           n_err = 0;
    int           mig_cnt = 0;
    int           snap;
    bit           ok;

    localparam logic [127:0] RD_DATA = 128'hDEAD_0011_2233_4455_6677_8899_AABB_BEEF;
    localparam logic [127:0] WR_DATA = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;

    tl_mig_bridge #(.TL_RS(5)) dut (
        .interconnect_clock_i(clk), .interconnect_reset_ni(rst_n),
        .slave_a_opcode(a_opcode), .slave_a_size(a_size), .slave_a_source(a_source),
        .slave_a_address(a_address), .slave_a_mask(a_mask), .slave_a_data(a_data),
        .slave_a_valid(a_valid), .slave_a_ready(a_ready),
        .slave_d_opcode(d_opcode), .slave_d_size(d_size), .slave_d_source(d_source),
        .slave_d_denied(d_denied), .slave_d_data(d_data), .slave_d_corrupt(d_corrupt),
        .slave_d_valid(d_valid), .slave_d_ready(d_ready),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (app_en || app_wdf_wren) mig_cnt <= mig_cnt + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [2:0] op, input logic [3:0] sz, input logic [4:0] src,
                          input logic [27:0] addr, input logic [15:0] msk, input logic [127:0] dat);
        int k = 0;
        @(negedge clk);
        while (!a_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("a_ready_timeout", 0, 1);
        a_opcode = op; a_size = sz; a_source = src; a_address = addr; a_mask = msk; a_data = dat;
        a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    task automatic wait_d(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = d_valid;
        end
        chk("d_valid_timeout", got, 1);
    endtask

    task automatic ack_d;
        d_ready = 1'b1;
        @(posedge clk);
        #1 d_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_app_en", app_en, 0);
        chk("rst_wren", app_wdf_wren, 0);
        rst_n = 1'b1;
        #1 chk("rel_a_ready_low", a_ready, 0);
        @(negedge clk);
        chk("rel_a_ready_high", a_ready, 1);

        // Get with delayed read return
        send_a(3'd4, 4'd4, 5'd5, 28'h0000120, 16'hFFFF, '0);
        @(negedge clk);
        chk("get_app_en", app_en, 1);
        chk("get_app_cmd", app_cmd, 3'd1);
        chk("get_app_addr", app_addr, 28'h0000120);
        chk("get_a_ready", a_ready, 0);
        @(negedge clk);
        chk("get_app_en_drop", app_en, 0);
        repeat (8) @(negedge clk);
        chk("get_no_early_d", d_valid, 0);
        app_rd_data = RD_DATA; app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
        @(posedge clk);
        #1 app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
        @(negedge clk);
        chk("get_d_valid", d_valid, 1);
        chk("get_d_opcode", d_opcode, 3'd1);
        chk("get_d_source", d_source, 5'd5);
        chk("get_d_size", d_size, 4'd4);
        chk("get_d_data", d_data, RD_DATA);
        chk("get_d_denied", d_denied, 0);
        chk("get_d_corrupt", d_corrupt, 0);
        ack_d;

        // PutPartial with write-data ready held off
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b0;
        send_a(3'd1, 4'd4, 5'd7, 28'h0000345, 16'h00FF, WR_DATA);
        @(negedge clk);
        chk("pp_app_en", app_en, 1);
        chk("pp_app_cmd", app_cmd, 3'd0);
        chk("pp_app_addr", app_addr, 28'h0000340);
        chk("pp_wren", app_wdf_wren, 1);
        chk("pp_wdf_end", app_wdf_end, 1);
        chk("pp_mask", app_wdf_mask, 16'hFF00);
        chk("pp_wdf_data", app_wdf_data, WR_DATA);
        @(negedge clk);
        chk("pp_cmd_first", app_en, 0);
        chk("pp_wren_held", app_wdf_wren, 1);
        @(posedge clk);
        #1 app_wdf_rdy = 1'b1;
        @(negedge clk);
        chk("pp_no_early_d", d_valid, 0);
        @(negedge clk);
        chk("pp_d_valid", d_valid, 1);
        chk("pp_d_opcode", d_opcode, 3'd0);
        chk("pp_d_source", d_source, 5'd7);
        chk("pp_d_denied", d_denied, 0);
        chk("pp_wren_drop", app_wdf_wren, 0);
        ack_d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pp_single_ack", d_valid, 0);
        end

        // refused requests
        snap = mig_cnt;
        send_a(3'd2, 4'd2, 5'd9, 28'h0000400, 16'hFFFF, '0);
        wait_d(ok);
        chk("arith_opcode", d_opcode, 3'd1);
        chk("arith_denied", d_denied, 1);
        chk("arith_corrupt", d_corrupt, 1);
        chk("arith_source", d_source, 5'd9);
        ack_d;
        send_a(3'd4, 4'd6, 5'd2, 28'h0000500, 16'hFFFF, '0);
        wait_d(ok);
        chk("big_get_opcode", d_opcode, 3'd1);
        chk("big_get_denied", d_denied, 1);
        chk("big_get_corrupt", d_corrupt, 1);
        ack_d;
        send_a(3'd5, 4'd2, 5'd3, 28'h0000600, 16'hFFFF, '0);
        wait_d(ok);
        chk("intent_opcode", d_opcode, 3'd0);
        chk("intent_denied", d_denied, 1);
        chk("intent_corrupt", d_corrupt, 0);
        ack_d;
        @(negedge clk);
        chk("denied_no_mig", mig_cnt, snap);

        // PutFull with D back-pressure
        send_a(3'd0, 4'd4, 5'd3, 28'h0ABCDE0, 16'hFFFF, WR_DATA);
        wait_d(ok);
        for (int i = 0; i < 5; i++) begin
            chk("bp_d_valid", d_valid, 1);
            chk("bp_a_ready", a_ready, 0);
            chk("bp_d_opcode", d_opcode, 3'd0);
            chk("bp_d_source", d_source, 5'd3);
            chk("bp_d_size", d_size, 4'd4);
            @(negedge clk);
        end
        chk("bp_a_ready_hs", a_ready, 0);
        ack_d;
        @(negedge clk);
        chk("bp_d_done", d_valid, 0);
        chk("bp_a_ready_back", a_ready, 1);

        // reset while waiting for read data
        send_a(3'd4, 4'd4, 5'd6, 28'h0000700, 16'hFFFF, '0);
        repeat (2) @(negedge clk);
        chk("rw_no_d", d_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("rw_a_ready", a_ready, 0);
        chk("rw_app_en", app_en, 0);
        chk("rw_app_addr", app_addr, 0);
        chk("rw_app_cmd", app_cmd, 0);
        chk("rw_d_source", d_source, 0);
        chk("rw_d_valid", d_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rw_a_ready_rel", a_ready, 1);
        app_rd_data = RD_DATA; app_rd_data_valid = 1'b1;
        @(posedge clk);
        #1 app_rd_data_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rw_stray_rd", d_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
